// File: rtl/arbitro_mux_dois_pkg.sv
// Shared definitions for the two-requester round-robin mux arbiter.
package arbitro_mux_dois_pkg;

    localparam int unsigned LARGURA_PADRAO    = 8;
    localparam int unsigned MAX_RAJADA_PADRAO = 4;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        POSSE0 = 2'd1,
        POSSE1 = 2'd2
    } estado_t;

    function automatic logic [1:0] decodifica_concede(input estado_t e);
        return {e == POSSE1, e == POSSE0};
    endfunction

endpackage

// File: rtl/MultiplexadorDois.sv
// 2:1 datapath multiplexer: selecao=0 picks entrada1, selecao=1 picks entrada2.
module MultiplexadorDois #(
    parameter int unsigned LARGURA = 8
) (
    input  logic [LARGURA-1:0] entrada1,
    input  logic [LARGURA-1:0] entrada2,
    input  logic               selecao,
    output logic [LARGURA-1:0] saida
);

    assign saida = selecao ? entrada2 : entrada1;

endmodule

// File: rtl/arbitro_mux_dois_contador.sv
// Burst counter: clear has priority, counts enabled cycles, saturates at MAX_RAJADA-1.
module contador_rajada #(
    parameter int unsigned MAX_RAJADA = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic limpa,
    input  logic habilita,
    output logic limite
);

    localparam int unsigned CW = $clog2(MAX_RAJADA) + 1;
    localparam logic [CW-1:0] TETO = CW'(MAX_RAJADA - 1);

    logic [CW-1:0] contagem;

    // MAX_RAJADA=0 means unlimited bursts, so the limit flag never rises.
    assign limite = (MAX_RAJADA > 0) && (contagem == TETO);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            contagem <= '0;
        end else if (limpa) begin
            contagem <= '0;
        end else if (habilita && !limite) begin
            contagem <= contagem + 1'b1;
        end
    end

endmodule

// File: rtl/arbitro_mux_dois.sv
// Round-robin arbiter sharing the 2:1 datapath mux between two requesters,
// with bounded bursts and a registered output word.
module arbitro_mux_dois
    import arbitro_mux_dois_pkg::*;
#(
    parameter int unsigned LARGURA    = LARGURA_PADRAO,
    parameter int unsigned MAX_RAJADA = MAX_RAJADA_PADRAO
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               req0,
    input  logic               req1,
    input  logic [LARGURA-1:0] entrada1,
    input  logic [LARGURA-1:0] entrada2,
    output logic [1:0]         concede,
    output logic               selecao,
    output logic [LARGURA-1:0] saida,
    output logic               valido
);

    estado_t            estado, prox;
    logic               ultimo;
    logic               transfere;
    logic               limite;
    logic               limpa;
    logic [LARGURA-1:0] dado_sel;

    MultiplexadorDois #(.LARGURA(LARGURA)) u_mux (
        .entrada1 (entrada1),
        .entrada2 (entrada2),
        .selecao  (selecao),
        .saida    (dado_sel)
    );

    contador_rajada #(.MAX_RAJADA(MAX_RAJADA)) u_contador (
        .clock    (clock),
        .reset_n  (reset_n),
        .limpa    (limpa),
        .habilita (transfere),
        .limite   (limite)
    );

    always_comb begin
        prox      = estado;
        transfere = 1'b0;
        case (estado)
            OCIOSO: begin
                if (req0 && req1)  prox = ultimo ? POSSE0 : POSSE1;
                else if (req0)     prox = POSSE0;
                else if (req1)     prox = POSSE1;
            end
            POSSE0: begin
                if (!req0) begin
                    prox = req1 ? POSSE1 : OCIOSO;
                end else begin
                    transfere = 1'b1;
                    if (limite && req1) prox = POSSE1;
                end
            end
            POSSE1: begin
                if (!req1) begin
                    prox = req0 ? POSSE0 : OCIOSO;
                end else begin
                    transfere = 1'b1;
                    if (limite && req0) prox = POSSE0;
                end
            end
            default: prox = OCIOSO;
        endcase
        limpa = (prox != estado);
    end

    // concede/selecao are registered from the next state so they track estado exactly.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado  <= OCIOSO;
            concede <= '0;
            selecao <= 1'b0;
            saida   <= '0;
            valido  <= 1'b0;
            ultimo  <= 1'b1;
        end else begin
            estado  <= prox;
            concede <= decodifica_concede(prox);
            if (prox == POSSE0)      selecao <= 1'b0;
            else if (prox == POSSE1) selecao <= 1'b1;
            valido <= transfere;
            if (transfere) saida <= dado_sel;
            if (estado == POSSE0 && prox != POSSE0) ultimo <= 1'b0;
            if (estado == POSSE1 && prox != POSSE1) ultimo <= 1'b1;
        end
    end

endmodule

// File: tb/tb_arbitro_mux_dois.sv
// Directed bench for arbitro_mux_dois with a queue of expected output words.
module tb_arbitro_mux_dois;

    logic       clock;
    logic       reset_n;
    logic       req0, req1;
    logic [7:0] entrada1, entrada2;
    logic [1:0] concede;
    logic       selecao;
    logic [7:0] saida;
    logic       valido;

    int unsigned compared   = 0;
    int unsigned mismatched = 0;
    logic [7:0]  fila[$];

    arbitro_mux_dois #(.LARGURA(8), .MAX_RAJADA(4)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .req0     (req0),
        .req1     (req1),
        .entrada1 (entrada1),
        .entrada2 (entrada2),
        .concede  (concede),
        .selecao  (selecao),
        .saida    (saida),
        .valido   (valido)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic confere(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        compared++;
        assert (obs === esp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, esp);
        end
    endtask

    // One clock cycle: drive at negedge, check grant before the edge, check output after it.
    task automatic ciclo(input logic r0, input logic r1, input logic [7:0] d0, input logic [7:0] d1,
                         input logic [1:0] esp_conc, input logic esp_xfer);
        logic [7:0] esp_dado;
        @(negedge clock);
        req0 = r0; req1 = r1; entrada1 = d0; entrada2 = d1;
        #1;
        confere("concede", 32'(concede), 32'(esp_conc));
        if (esp_conc != 2'b00) confere("selecao", 32'(selecao), 32'(esp_conc[1]));
        if (esp_xfer) fila.push_back(esp_conc[1] ? d1 : d0);
        @(posedge clock);
        #1;
        confere("valido", 32'(valido), 32'(esp_xfer));
        if (esp_xfer) begin
            if (fila.size() == 0) begin
                confere("fila_vazia_inesperada", 32'd1, 32'd0);
            end else begin
                esp_dado = fila.pop_front();
                confere("saida", 32'(saida), 32'(esp_dado));
            end
        end
    endtask

    always @(negedge clock) begin
        if (reset_n === 1'b1) begin
            compared++;
            assert (concede !== 2'b11) else begin
                mismatched++;
                $error("FAIL concede_onehot: observed %b expected not 11", concede);
            end
            if (concede != 2'b00) begin
                compared++;
                assert (selecao === concede[1]) else begin
                    mismatched++;
                    $error("FAIL selecao_inv: observed %b expected %b", selecao, concede[1]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0; req0 = 1'b1; req1 = 1'b1; entrada1 = 8'h00; entrada2 = 8'h00;
        repeat (2) @(posedge clock);
        #1;
        confere("rst_concede", 32'(concede), 32'd0);
        confere("rst_selecao", 32'(selecao), 32'd0);
        confere("rst_valido",  32'(valido),  32'd0);
        confere("rst_saida",   32'(saida),   32'd0);
        reset_n = 1'b1;

        // tie after reset goes to requester 0, then direct handoff, then round-robin
        ciclo(1, 1, 8'h10, 8'h20, 2'b00, 0);
        ciclo(1, 1, 8'h11, 8'h21, 2'b01, 1);
        ciclo(0, 1, 8'h15, 8'h25, 2'b01, 0);
        ciclo(0, 1, 8'h12, 8'h22, 2'b10, 1);
        ciclo(0, 0, 8'h16, 8'h26, 2'b10, 0);
        ciclo(1, 1, 8'h13, 8'h23, 2'b00, 0);
        ciclo(0, 0, 8'h17, 8'h27, 2'b01, 0);

        // single owner on requester 1
        ciclo(0, 1, 8'hF0, 8'h01, 2'b00, 0);
        ciclo(0, 1, 8'hF1, 8'h02, 2'b10, 1);
        ciclo(0, 1, 8'hF2, 8'h03, 2'b10, 1);
        ciclo(0, 1, 8'hF3, 8'h04, 2'b10, 1);
        ciclo(0, 0, 8'hF4, 8'h05, 2'b10, 0);
        ciclo(0, 0, 8'hF5, 8'h06, 2'b00, 0);

        // burst limit: exactly four transfers of entrada1 while req1 waits
        ciclo(1, 0, 8'hA0, 8'hB0, 2'b00, 0);
        ciclo(1, 1, 8'hA1, 8'hB1, 2'b01, 1);
        ciclo(1, 1, 8'hA2, 8'hB2, 2'b01, 1);
        ciclo(1, 1, 8'hA3, 8'hB3, 2'b01, 1);
        ciclo(1, 1, 8'hA4, 8'hB4, 2'b01, 1);
        ciclo(1, 1, 8'hA5, 8'hB5, 2'b10, 1);
        ciclo(1, 0, 8'hA6, 8'hB6, 2'b10, 0);

        // requester 0 alone keeps the bus past the limit
        for (int i = 0; i < 8; i++) begin
            ciclo(1, 0, 8'hC0 + 8'(i), 8'hD0 + 8'(i), 2'b01, 1);
        end
        ciclo(1, 1, 8'hC8, 8'hD8, 2'b01, 1);
        ciclo(0, 1, 8'hC9, 8'hD9, 2'b10, 1);

        // async reset pulse between edges while requester 1 owns the bus
        #1;
        reset_n = 1'b0;
        #1;
        confere("arst_concede", 32'(concede), 32'd0);
        confere("arst_selecao", 32'(selecao), 32'd0);
        confere("arst_valido",  32'(valido),  32'd0);
        confere("arst_saida",   32'(saida),   32'd0);
        reset_n = 1'b1;
        ciclo(0, 0, 8'h55, 8'h66, 2'b00, 0);

        confere("fila_final", 32'(fila.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
